dest_demux_4: RTL and testbench



---
 rtl/dest_demux_4_if.sv | 36 +++
 rtl/dest_demux_4.sv | 101 ++++++++++
 tb/tb_dest_demux_4.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dest_demux_4_if.sv
// Bus bundle for dest_demux_4: upstream FIFO read side (pop/empty) and the
// four downstream FIFO write sides (push/almost_full) sharing one data bus.
interface dest_demux_4_if #(
  parameter int BW = 6
);
  logic          empty_in;
  logic [BW-1:0] data_in;
  logic          pop_in;
  logic          almost_full_P0;
  logic          almost_full_P1;
  logic          almost_full_P2;
  logic          almost_full_P3;
  logic          push_P0;
  logic          push_P1;
  logic          push_P2;
  logic          push_P3;
  logic [BW-1:0] data_out;

  // The demux itself.
  modport slave (
    input  empty_in, data_in,
    input  almost_full_P0, almost_full_P1, almost_full_P2, almost_full_P3,
    output pop_in,
    output push_P0, push_P1, push_P2, push_P3,
    output data_out
  );

  // The FIFOs around it.
  modport master (
    output empty_in, data_in,
    output almost_full_P0, almost_full_P1, almost_full_P2, almost_full_P3,
    input  pop_in,
    input  push_P0, push_P1, push_P2, push_P3,
    input  data_out
  );
endinterface

// File: rtl/dest_demux_4.sv
// Drains one upstream FIFO and steers each word to P0..P3 by its in-word dest field.
// Optional per-port push counters cnt_P0..cnt_P3 are enabled with `define DEST_DEMUX_CNT_EN.
module dest_demux_4 #(
  parameter int BW       = 6,
  parameter int DEST_LSB = 4,
  parameter int AF_BLOCK = 1
) (
  input  logic           clk,
  input  logic           reset,
  dest_demux_4_if.slave  bus
`ifdef DEST_DEMUX_CNT_EN
  ,
  output logic [7:0]     cnt_P0,
  output logic [7:0]     cnt_P1,
  output logic [7:0]     cnt_P2,
  output logic [7:0]     cnt_P3
`endif
);

  logic [BW-1:0] buf_q [2];
  logic          hd_q, hd_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          pending_q;

  logic [BW-1:0] head;
  logic [1:0]    dest;
  logic [3:0]    af;
  logic [3:0]    push;
  logic          blocked;
  logic          drain;
  logic          pop;
  logic [2:0]    occ;
  logic          tail;

  // NOTE: every signal assigned in always_comb gets a value on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    head    = buf_q[hd_q];
    dest    = head[DEST_LSB+1:DEST_LSB];
    af      = {bus.almost_full_P3, bus.almost_full_P2,
               bus.almost_full_P1, bus.almost_full_P0};
    blocked = (AF_BLOCK != 0) && af[dest];
    drain   = !reset && (cnt_q != 2'd0) && !blocked;
    push    = drain ? (4'b0001 << dest) : 4'b0000;
    // Words buffered after this edge; a new pop is allowed only if one slot stays free.
    occ     = {1'b0, cnt_q} + {2'b00, pending_q} - {2'b00, drain};
    pop     = !reset && !bus.empty_in && (occ <= 3'd1);
    cnt_d   = occ[1:0];
    hd_d    = hd_q ^ drain;
    tail    = hd_q ^ cnt_q[0];
  end

  assign bus.pop_in   = pop;
  assign bus.push_P0  = push[0];
  assign bus.push_P1  = push[1];
  assign bus.push_P2  = push[2];
  assign bus.push_P3  = push[3];
  assign bus.data_out = (!reset && (cnt_q != 2'd0)) ? head : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= 2'd0;
      hd_q      <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      hd_q      <= hd_d;
      pending_q <= pop;
    end
  end

  // NOTE: the data storage is deliberately not reset; cnt_q marks which
  // entries are valid, so resetting the payload would only cost logic.
  always_ff @(posedge clk) begin
    if (!reset && pending_q) begin
      buf_q[tail] <= bus.data_in;
    end
  end

`ifdef DEST_DEMUX_CNT_EN
  logic [7:0] cnt_px_q [4];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) cnt_px_q[i] <= 8'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (push[i]) cnt_px_q[i] <= cnt_px_q[i] + 8'd1;
      end
    end
  end

  assign cnt_P0 = cnt_px_q[0];
  assign cnt_P1 = cnt_px_q[1];
  assign cnt_P2 = cnt_px_q[2];
  assign cnt_P3 = cnt_px_q[3];
`endif

endmodule

// File: tb/tb_dest_demux_4.sv
// Scoreboard bench for dest_demux_4: an upstream FIFO model feeds words, every
// pop queues the expected word, every push is popped and checked for data and port.
module tb_dest_demux_4;
  localparam int BW = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dest_demux_4_if #(.BW(BW)) bus ();

`ifdef DEST_DEMUX_CNT_EN
  logic [7:0] cnt_P0, cnt_P1, cnt_P2, cnt_P3;
`endif

  dest_demux_4 #(.BW(BW), .DEST_LSB(4), .AF_BLOCK(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef DEST_DEMUX_CNT_EN
    ,
    .cnt_P0 (cnt_P0),
    .cnt_P1 (cnt_P1),
    .cnt_P2 (cnt_P2),
    .cnt_P3 (cnt_P3)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_push = 0;
  int n_pop  = 0;

  logic [BW-1:0] up_q [$];
  logic [BW-1:0] sb_q [$];
  bit            empty_gate = 1'b0;
  bit            inflight;
  logic [BW-1:0] inflight_w;

  logic          obs_pop;
  logic [3:0]    obs_push;
  logic [BW-1:0] obs_data;

  task automatic refresh();
    bus.empty_in = (up_q.size() == 0) || empty_gate;
  endtask

  task automatic set_af(input logic [3:0] v);
    bus.almost_full_P0 = v[0];
    bus.almost_full_P1 = v[1];
    bus.almost_full_P2 = v[2];
    bus.almost_full_P3 = v[3];
  endtask

  // One clock: sample at negedge, score pushes/pops, then drive next inputs #1 after posedge.
  task automatic tick();
    logic [BW-1:0] w;
    @(negedge clk);
    obs_pop  = bus.pop_in;
    obs_push = {bus.push_P3, bus.push_P2, bus.push_P1, bus.push_P0};
    obs_data = bus.data_out;
    cyc++;
    n_cmp++;
    if ($countones(obs_push) > 1) begin
      n_err++;
      $display("FAIL onehot cyc=%0d push=%b required at most one bit", cyc, obs_push);
    end
    if (obs_push != 4'b0000) begin
      n_push++;
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL push_without_pop cyc=%0d push=%b data=%h required no push", cyc, obs_push, obs_data);
      end else begin
        w = sb_q.pop_front();
        if (obs_data !== w || obs_push !== (4'b0001 << w[5:4])) begin
          n_err++;
          $display("FAIL scoreboard cyc=%0d got push=%b data=%h required push=%b data=%h",
                   cyc, obs_push, obs_data, 4'b0001 << w[5:4], w);
        end
      end
    end
    inflight = 1'b0;
    if (obs_pop === 1'b1) begin
      n_cmp++;
      if (up_q.size() == 0) begin
        n_err++;
        $display("FAIL pop_when_empty cyc=%0d pop=1 required 0", cyc);
      end else begin
        w = up_q.pop_front();
        sb_q.push_back(w);
        inflight   = 1'b1;
        inflight_w = w;
        n_pop++;
      end
    end
    @(posedge clk);
    #1;
    bus.data_in = inflight ? inflight_w : BW'($urandom);
    refresh();
  endtask

  task automatic run_until_empty(input int budget, output bit ok);
    ok = 1'b0;
    repeat (budget) begin
      if (up_q.size() == 0 && sb_q.size() == 0) break;
      tick();
    end
    ok = (up_q.size() == 0 && sb_q.size() == 0);
  endtask

  task automatic start_reset();
    reset = 1'b1;
    sb_q.delete();
    up_q.delete();
    inflight = 1'b0;
    refresh();
  endtask

  task automatic test_reset();
    bit ok;
    int p0;
    start_reset();
    up_q.push_back(6'h0A);
    up_q.push_back(6'h1B);
    refresh();
    repeat (2) begin
      tick();
      n_cmp++;
      if (obs_pop !== 1'b0 || obs_push !== 4'b0000 || obs_data !== '0) begin
        n_err++;
        $display("FAIL reset_outputs pop=%b push=%b data=%h required 0/0000/00", obs_pop, obs_push, obs_data);
      end
    end
    reset = 1'b0;
    p0 = n_push;
    tick();
    n_cmp++;
    if (obs_pop !== 1'b1) begin
      n_err++;
      $display("FAIL first_pop_after_reset pop=%b required 1", obs_pop);
    end
    run_until_empty(20, ok);
    n_cmp++;
    if (!ok || n_push - p0 != 2) begin
      n_err++;
      $display("FAIL reset_drain ok=%0d pushes=%0d required 1/2", ok, n_push - p0);
    end
  endtask

  task automatic test_stream();
    logic [BW-1:0] exp_w [4];
    int pop_c [$];
    int push_c [$];
    logic [BW-1:0] push_d [$];
    logic [3:0] push_p [$];
    exp_w[0] = 6'h05; exp_w[1] = 6'h12; exp_w[2] = 6'h23; exp_w[3] = 6'h34;
    set_af(4'b0000);
    for (int k = 0; k < 4; k++) up_q.push_back(exp_w[k]);
    refresh();
    repeat (10) begin
      tick();
      if (obs_pop === 1'b1) pop_c.push_back(cyc);
      if (obs_push != 4'b0000) begin
        push_c.push_back(cyc);
        push_d.push_back(obs_data);
        push_p.push_back(obs_push);
      end
    end
    n_cmp++;
    if (pop_c.size() != 4 || pop_c[3] - pop_c[0] != 3) begin
      n_err++;
      $display("FAIL stream_pops count=%0d required 4 consecutive", pop_c.size());
    end
    n_cmp++;
    if (push_c.size() != 4) begin
      n_err++;
      $display("FAIL stream_push_count got=%0d required 4", push_c.size());
    end else if (pop_c.size() > 0) begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (push_c[k] != pop_c[0] + 2 + k || push_d[k] !== exp_w[k] || push_p[k] !== (4'b0001 << k)) begin
          n_err++;
          $display("FAIL stream_word%0d cyc=%0d data=%h port=%b required cyc=%0d data=%h port=%b",
                   k, push_c[k], push_d[k], push_p[k], pop_c[0] + 2 + k, exp_w[k], 4'b0001 << k);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int pp, ph;
    logic [BW-1:0] push_d [$];
    logic [3:0]    push_p [$];
    set_af(4'b0010);
    up_q.push_back(6'h11);
    up_q.push_back(6'h02);
    up_q.push_back(6'h03);
    refresh();
    pp = n_pop;
    ph = n_push;
    repeat (8) tick();
    n_cmp++;
    if (n_pop - pp != 2 || n_push - ph != 0 || obs_pop !== 1'b0 || obs_data !== 6'h11) begin
      n_err++;
      $display("FAIL bp_hold pops=%0d pushes=%0d pop=%b head=%h required 2/0/0/11",
               n_pop - pp, n_push - ph, obs_pop, obs_data);
    end
    set_af(4'b0000);
    repeat (8) begin
      tick();
      if (obs_push != 4'b0000) begin
        push_d.push_back(obs_data);
        push_p.push_back(obs_push);
      end
    end
    n_cmp++;
    if (push_d.size() != 3) begin
      n_err++;
      $display("FAIL bp_release_count got=%0d required 3", push_d.size());
    end else begin
      n_cmp++;
      if (push_p[0] !== 4'b0010 || push_d[0] !== 6'h11 ||
          push_p[1] !== 4'b0001 || push_d[1] !== 6'h02 ||
          push_p[2] !== 4'b0001 || push_d[2] !== 6'h03) begin
        n_err++;
        $display("FAIL bp_release_order got %b:%h %b:%h %b:%h required 0010:11 0001:02 0001:03",
                 push_p[0], push_d[0], push_p[1], push_d[1], push_p[2], push_d[2]);
      end
    end
  endtask

  task automatic test_empty_toggle();
    int pp, ph;
    bit ok;
    for (int k = 0; k < 8; k++) up_q.push_back(6'h20 + 6'(k));
    pp = n_pop;
    ph = n_push;
    ok = 1'b0;
    repeat (60) begin
      if (up_q.size() == 0 && sb_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      empty_gate = ~empty_gate;
      refresh();
      tick();
    end
    empty_gate = 1'b0;
    refresh();
    n_cmp++;
    if (!ok || n_pop - pp != 8 || n_push - ph != 8) begin
      n_err++;
      $display("FAIL empty_toggle ok=%0d pops=%0d pushes=%0d required 1/8/8", ok, n_pop - pp, n_push - ph);
    end
  endtask

  task automatic test_reset_mid();
    int ph;
    bit ok;
    set_af(4'b1000);
    up_q.push_back(6'h30);
    up_q.push_back(6'h31);
    up_q.push_back(6'h32);
    refresh();
    tick();
    tick();
    repeat (2) tick();
    start_reset();
    ph = n_push;
    tick();
    reset = 1'b0;
    set_af(4'b0000);
    tick();
    n_cmp++;
    if (obs_push !== 4'b0000 || obs_data !== '0) begin
      n_err++;
      $display("FAIL reset_mid_flush push=%b data=%h required 0000/00", obs_push, obs_data);
    end
    repeat (3) tick();
    up_q.push_back(6'h3C);
    refresh();
    run_until_empty(20, ok);
    n_cmp++;
    if (!ok || n_push - ph != 1) begin
      n_err++;
      $display("FAIL reset_mid_resume ok=%0d pushes=%0d required 1/1", ok, n_push - ph);
    end
  endtask

  task automatic test_back_to_back();
    int ph;
    bit ok;
    for (int k = 0; k < 40; k++) up_q.push_back(BW'($urandom));
    refresh();
    ph = n_push;
    repeat (600) begin
      if (up_q.size() == 0 && sb_q.size() == 0) break;
      set_af({$urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0});
      tick();
    end
    set_af(4'b0000);
    run_until_empty(20, ok);
    n_cmp++;
    if (!ok || n_push - ph != 40) begin
      n_err++;
      $display("FAIL back_to_back ok=%0d pushes=%0d required 1/40", ok, n_push - ph);
    end
  endtask

`ifdef DEST_DEMUX_CNT_EN
  task automatic test_counters();
    bit ok;
    start_reset();
    repeat (2) tick();
    reset = 1'b0;
    for (int k = 0; k < 300; k++) up_q.push_back(6'h30 | BW'($urandom_range(0, 15)));
    refresh();
    run_until_empty(700, ok);
    n_cmp++;
    if (!ok || cnt_P3 !== 8'd44 || cnt_P0 !== 8'd0 || cnt_P1 !== 8'd0 || cnt_P2 !== 8'd0) begin
      n_err++;
      $display("FAIL counters ok=%0d cnt=%0d/%0d/%0d/%0d required 1 0/0/0/44",
               ok, cnt_P0, cnt_P1, cnt_P2, cnt_P3);
    end
    start_reset();
    tick();
    reset = 1'b0;
    n_cmp++;
    if (cnt_P0 !== 8'd0 || cnt_P1 !== 8'd0 || cnt_P2 !== 8'd0 || cnt_P3 !== 8'd0) begin
      n_err++;
      $display("FAIL counters_reset cnt=%0d/%0d/%0d/%0d required 0/0/0/0", cnt_P0, cnt_P1, cnt_P2, cnt_P3);
    end
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d required finish before time limit", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    bus.data_in = '0;
    set_af(4'b0000);
    refresh();
    test_reset();
    test_stream();
    test_backpressure();
    test_empty_toggle();
    test_reset_mid();
    test_back_to_back();
`ifdef DEST_DEMUX_CNT_EN
    test_counters();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
